conv2d_requant_stream: RTL
==========================

// Module: conv2d_requant_stream
// PURPOSE
//  Downstream stage of conv2d_feature: on each conv done, snapshots the wide accumulator vector
//  (FEATURE_MAP_NUM x KERNEL_NUM results), adds per-kernel bias, optional ReLU, rounds/right-shifts,
//  saturates to BITWIDTH and streams results one element per cycle over valid/ready to the next layer.
// PARAMETERS
//  BITWIDTH                 8  output element width (signed)
//  IS_BITWIDTH_DOUBLE_SCALE 1  accumulator width ACC_W = BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1)
//  FEATURE_MAP_NUM          9  output pixels per conv pass (systolic rows)
//  KERNEL_NUM               1  output channels per pass (systolic cols)
// PORTS
//  clk             in   1                         clock, rising edge
//  rst_n           in   1                         asynchronous reset, active low
//  calculate_done  in   1                         done level from conv2d_feature; rising edge = new result
//  channel_in      in   ACC_W*FEATURE_MAP_NUM*KERNEL_NUM  signed accumulators; elem(r,k) at [(r*KERNEL_NUM+k)*ACC_W +: ACC_W]
//  bias            in   ACC_W*KERNEL_NUM          signed bias; kernel k at [k*ACC_W +: ACC_W]; sampled at capture
//  shift           in   $clog2(ACC_W)             arithmetic right shift amount; sampled at capture
//  relu_en         in   1                         1 = clamp negatives to 0; sampled at capture
//  in_ready        out  1                         1 when IDLE (new result will be accepted)
//  busy            out  1                         1 while a captured result is not fully drained
//  overrun         out  1                         sticky: done edge arrived while busy
//  overrun_clr     in   1                         synchronous clear of overrun
//  out_valid       out  1                         out_data valid
//  out_ready       in   1                         consumer accept
//  out_data        out  BITWIDTH                  signed requantized element
//  out_kernel      out  $clog2(KERNEL_NUM) (min 1) kernel index of out_data
//  out_pixel       out  $clog2(FEATURE_MAP_NUM) (min 1) pixel index of out_data
//  out_last        out  1                         1 on final element of the pass
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, busy=0, overrun=0, out_valid=0, out_data/out_kernel/out_pixel/out_last=0,
//   done_q=0 (edge detector). Reset mid-stream drops remaining elements; no partial output after release.
//  Edge detect: cap = calculate_done & ~done_q. done_q registered every cycle.
//  FSM IDLE: cap -> latch channel_in, bias, shift, relu_en into snapshot regs; k=0,r=0; -> STREAM.
//  FSM STREAM: output reg loads elem(r,k) when (!out_valid | out_ready); index advances r fastest
//   (order: k outer, r inner). After loading final element (r=FMN-1,k=KN-1, out_last=1) -> DRAIN.
//  FSM DRAIN: out_valid & out_ready -> out_valid=0, IDLE. Same cycle cap can be captured next cycle only.
//  Latency: cap in cycle N -> first out_valid in N+2; with out_ready=1 throughout, one element/cycle,
//   pass completes in FMN*KN cycles; in_ready returns 1 one cycle after last handshake.
//  Handshake: out_valid never drops and out_data/out_kernel/out_pixel/out_last stable while out_valid&!out_ready.
//  cap while busy: ignored (snapshot untouched), overrun<=1; overrun_clr wins over simultaneous set? no: set wins.
//  Arithmetic per element: s = sext(acc)+sext(bias[k]) in ACC_W+1 bits; if relu_en & s<0 -> s=0;
//   if shift>0: s = (s + (1<<(shift-1))) >>> shift (round half up, ACC_W+2 bits, no overflow); else s unchanged;
//   out = sat(s) to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
//  busy = (state != IDLE); in_ready = ~busy.
// STRUCTURE
//  Package conv_pkg: ACC_W function, sat/rounding helper functions, FSM state enum (IDLE/STREAM/DRAIN).
//  One sub-module: requant_lane (combinational acc+bias+relu+round+shift+sat, one element); top holds
//  snapshot regs, edge detect, FSM, index counters, output register.
// TESTING (ACC_W=16, BITWIDTH=8, FMN=9, KN=1 unless noted)
//  Basic: all acc=300, bias=-44, shift=4, relu=1, out_ready=1 -> 9 outputs of 16, pixels 0..8, out_last on 9th, out_valid at N+2.
//  Rounding/sat: acc0=24,shift=4 -> 2; acc1=32767,bias=100,shift=0 -> 127; acc2=-1000,shift=2,relu=0 -> -128; relu=1 -> 0.
//  Backpressure: out_ready toggles 1,0,0,1 random -> outputs stable while stalled, order/values identical to basic, no loss/dup.
//  Overrun: second done edge during STREAM -> overrun=1, stream values from first capture unchanged; overrun_clr -> 0.
//  Multi-kernel (KN=2, bias={k1:10,k0:-10}, acc=100, shift=0): 18 outputs, k=0 pixels 0..8 =90 then k=1 =110.
//  Reset mid-stream after 4 handshakes -> all outputs reset values immediately; next done edge restarts from pixel 0.

Source files
------------

// File: rtl/conv2d_requant_stream_pkg.sv
// Shared types and arithmetic helpers for the conv2d requantization stream.
// Helpers work at 64 bits so any ACC_W up to 60 fits without overflow.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   function automatic int acc_w(input int bw, input int dbl);
      return bw * (dbl + 1);
   endfunction

   // Add half an output LSB, then floor-shift: round half toward +inf.
   function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
      if (sh > 0)
         return (v + (64'sd1 <<< (sh - 1))) >>> sh;
      return v;
   endfunction

   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int bw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv2d_requant_stream_lane.sv
// One element of requantization: acc + bias, optional ReLU, rounded shift, saturate.
module requant_lane
   import conv_pkg::*;
#(
   parameter int ACC_W    = 16,
   parameter int BITWIDTH = 8,
   parameter int SH_W     = 4
)(
   input  logic signed [ACC_W-1:0]    acc,
   input  logic signed [ACC_W-1:0]    bias,
   input  logic        [SH_W-1:0]     shift,
   input  logic                       relu_en,
   output logic signed [BITWIDTH-1:0] q
);

   logic signed [63:0] sum;
   logic signed [63:0] shr;

   always_comb begin
      sum = 64'(acc) + 64'(bias);
      if (relu_en && sum < 0)
         sum = '0;
      shr = rnd_shr(sum, int'(shift));
      q   = BITWIDTH'(sat_to(shr, BITWIDTH));
   end

endmodule

// File: rtl/conv2d_requant_stream.sv
// Snapshots conv accumulators on each done edge and streams requantized elements
// one per cycle over valid/ready, kernel-major then pixel order.
module conv2d_requant_stream
   import conv_pkg::*;
#(
   parameter  int BITWIDTH                 = 8,
   parameter  int IS_BITWIDTH_DOUBLE_SCALE = 1,
   parameter  int FEATURE_MAP_NUM          = 9,
   parameter  int KERNEL_NUM               = 1,
   localparam int ACC_W = acc_w(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE),
   localparam int SH_W  = $clog2(ACC_W),
   localparam int KW    = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1,
   localparam int PW    = (FEATURE_MAP_NUM > 1) ? $clog2(FEATURE_MAP_NUM) : 1
)(
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       calculate_done,
   input  logic [ACC_W*FEATURE_MAP_NUM*KERNEL_NUM-1:0] channel_in,
   input  logic [ACC_W*KERNEL_NUM-1:0]                bias,
   input  logic [SH_W-1:0]                            shift,
   input  logic                                       relu_en,
   output logic                                       in_ready,
   output logic                                       busy,
   output logic                                       overrun,
   input  logic                                       overrun_clr,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic signed [BITWIDTH-1:0]                 out_data,
   output logic [KW-1:0]                              out_kernel,
   output logic [PW-1:0]                              out_pixel,
   output logic                                       out_last
);

   localparam int NE = FEATURE_MAP_NUM * KERNEL_NUM;
   localparam int EW = (NE > 1) ? $clog2(NE) : 1;
   localparam logic [PW-1:0] R_LAST = PW'(FEATURE_MAP_NUM - 1);
   localparam logic [KW-1:0] K_LAST = KW'(KERNEL_NUM - 1);

   state_t                             state;
   logic                               done_q;
   logic                               cap;
   logic [NE-1:0][ACC_W-1:0]           acc_snap;
   logic [KERNEL_NUM-1:0][ACC_W-1:0]   bias_snap;
   logic [SH_W-1:0]                    shift_q;
   logic                               relu_q;
   logic [PW-1:0]                      r_idx;
   logic [KW-1:0]                      k_idx;
   logic [EW-1:0]                      elem_idx;
   logic                               is_final;
   logic signed [BITWIDTH-1:0]         lane_q;

   assign cap      = calculate_done & ~done_q;
   assign busy     = (state != ST_IDLE);
   assign in_ready = ~busy;
   assign is_final = (r_idx == R_LAST) && (k_idx == K_LAST);
   assign elem_idx = EW'(32'(r_idx) * 32'(KERNEL_NUM) + 32'(k_idx));

   requant_lane #(
      .ACC_W    (ACC_W),
      .BITWIDTH (BITWIDTH),
      .SH_W     (SH_W)
   ) u_lane (
      .acc     (acc_snap[elem_idx]),
      .bias    (bias_snap[k_idx]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .q       (lane_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         done_q     <= 1'b0;
         overrun    <= 1'b0;
         acc_snap   <= '0;
         bias_snap  <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         r_idx      <= '0;
         k_idx      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_kernel <= '0;
         out_pixel  <= '0;
         out_last   <= 1'b0;
      end else begin
         done_q <= calculate_done;
         // A new result arriving mid-pass is dropped; set beats a same-cycle clear.
         if (cap && state != ST_IDLE)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (cap) begin
                  acc_snap  <= channel_in;
                  bias_snap <= bias;
                  shift_q   <= shift;
                  relu_q    <= relu_en;
                  r_idx     <= '0;
                  k_idx     <= '0;
                  state     <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (!out_valid || out_ready) begin
                  out_valid  <= 1'b1;
                  out_data   <= lane_q;
                  out_kernel <= k_idx;
                  out_pixel  <= r_idx;
                  out_last   <= is_final;
                  if (is_final) begin
                     state <= ST_DRAIN;
                  end else if (r_idx == R_LAST) begin
                     r_idx <= '0;
                     k_idx <= k_idx + 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
